// File: rtl/letter_scroll_scheduler.sv
// letter_scroll_scheduler
// Keeps the most recent DIGITS decoded Morse letters in a scrolling buffer.
// Time-multiplexes those letters onto one shared letter-to-segment lookup.
// Drives active-low digit enables, with a short all-off guard at the start
// of every digit slot so the lookup output settles before a digit lights.

module letter_scroll_scheduler #(
   parameter int DIGITS       = 4,
   parameter int REFRESH_DIV  = 1000,
   parameter int BLANK_CYCLES = 2
) (
   input  logic              clock,
   input  logic              clear,
   input  logic              newletter,
   input  logic [5:0]        letter,
   input  logic              flush,
   output logic [5:0]        letterQ,
   output logic [DIGITS-1:0] an,
   output logic              accepted,
   output logic [3:0]        count
);

   localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   // Code that the segment lookup renders as all segments off
   localparam logic [5:0]       NULL_CODE  = 6'b100111;
   // Highest code that is a real letter (0..9, A..Z)
   localparam logic [5:0]       LAST_VALID = 6'd35;
   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);
   localparam logic [3:0]       COUNT_MAX  = 4'(DIGITS);

   typedef enum logic {
      BLANK = 1'b0,
      DRIVE = 1'b1
   } scanState_t;

   scanState_t        r_state;
   scanState_t        w_nextState;
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  w_cntNext;
   logic              w_cntWrap;
   logic [IDX_W-1:0]  r_idx;
   logic [IDX_W-1:0]  w_idxNext;
   logic [DIGITS-1:0] r_an;
   logic [DIGITS-1:0] w_anNext;

   logic [5:0]        r_slot [DIGITS];
   logic [5:0]        r_letterQ;
   logic              r_accepted;
   logic [3:0]        r_count;
   logic              w_accept;

   // A letter enters the buffer only if it is a real code and no flush is pending;
   // flush always wins over a simultaneous strobe
   assign w_accept = newletter && !flush && (letter <= LAST_VALID);

   // Slot counter and digit index: idx only moves on when the slot counter wraps
   always_comb begin
      w_cntWrap = (r_cnt == CNT_LAST);
      w_cntNext = r_cnt + 1'b1;
      w_idxNext = r_idx;
      if (w_cntWrap) begin
         w_cntNext = '0;
         if (r_idx == IDX_LAST) begin
            w_idxNext = '0;
         end else begin
            w_idxNext = r_idx + 1'b1;
         end
      end
   end

   // Scan FSM next state plus the matching enable pattern, so that an, cnt and idx
   // are all registered together on the same edge
   always_comb begin
      w_nextState = r_state;
      w_anNext    = '1;
      case (r_state)
         BLANK: begin
            if (r_cnt == BLANK_LAST) begin
               w_nextState = DRIVE;
            end
         end
         DRIVE: begin
            if (w_cntWrap) begin
               w_nextState = BLANK;
            end
         end
         default: begin
            w_nextState = BLANK;
         end
      endcase
      if (w_nextState == DRIVE) begin
         w_anNext[w_idxNext] = 1'b0;
      end
   end

   // Scan state register; clear drops every enable high immediately
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         r_state <= BLANK;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_an    <= '1;
      end else begin
         r_state <= w_nextState;
         r_cnt   <= w_cntNext;
         r_idx   <= w_idxNext;
         r_an    <= w_anNext;
      end
   end

   // Scrolling letter buffer: slot 0 is the newest and feeds the rightmost digit
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         for (int i = 0; i < DIGITS; i++) begin
            r_slot[i] <= NULL_CODE;
         end
      end else if (flush) begin
         for (int i = 0; i < DIGITS; i++) begin
            r_slot[i] <= NULL_CODE;
         end
      end else if (w_accept) begin
         for (int i = DIGITS - 1; i > 0; i--) begin
            r_slot[i] <= r_slot[i-1];
         end
         r_slot[0] <= letter;
      end
   end

   // Occupied-slot count saturates at DIGITS because the oldest letter drops off
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         r_count <= '0;
      end else if (flush) begin
         r_count <= '0;
      end else if (w_accept && (r_count != COUNT_MAX)) begin
         r_count <= r_count + 1'b1;
      end
   end

   // One-cycle acknowledge for each letter that made it into the buffer
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         r_accepted <= 1'b0;
      end else begin
         r_accepted <= w_accept;
      end
   end

   // Present the slot selected by the current digit index to the lookup every cycle;
   // the blank guard at the start of each slot hides the one-cycle lag
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         r_letterQ <= NULL_CODE;
      end else begin
         r_letterQ <= r_slot[r_idx];
      end
   end

   assign letterQ  = r_letterQ;
   assign an       = r_an;
   assign accepted = r_accepted;
   assign count    = r_count;

endmodule

// File: tb/tb_letter_scroll_scheduler.sv
// Testbench for letter_scroll_scheduler.
// A small behavioural model tracks the buffer as an array and derives the scan
// position from the number of clock edges since reset release.

module tb_letter_scroll_scheduler;

   localparam int DIGITS       = 4;
   localparam int REFRESH_DIV  = 8;
   localparam int BLANK_CYCLES = 2;
   localparam logic [5:0] NULL_CODE = 6'b100111;

   logic              clock = 1'b0;
   logic              clear;
   logic              newletter;
   logic [5:0]        letter;
   logic              flush;
   logic [5:0]        letterQ;
   logic [DIGITS-1:0] an;
   logic              accepted;
   logic [3:0]        count;

   int nCompared   = 0;
   int nMismatched = 0;

   logic [5:0] mSlot [DIGITS];
   int         mCount;
   logic       mAccepted;
   logic [5:0] mLetterQ;
   int         mEdges;

   letter_scroll_scheduler #(
      .DIGITS      (DIGITS),
      .REFRESH_DIV (REFRESH_DIV),
      .BLANK_CYCLES(BLANK_CYCLES)
   ) dut (
      .clock    (clock),
      .clear    (clear),
      .newletter(newletter),
      .letter   (letter),
      .flush    (flush),
      .letterQ  (letterQ),
      .an       (an),
      .accepted (accepted),
      .count    (count)
   );

   // Free-running 10-unit clock
   always #5 clock = ~clock;

   // Model back to its reset state: empty buffer, scan at slot 0 cycle 0
   function automatic void modelReset();
      for (int i = 0; i < DIGITS; i++) mSlot[i] = NULL_CODE;
      mCount    = 0;
      mAccepted = 1'b0;
      mLetterQ  = NULL_CODE;
      mEdges    = 0;
   endfunction

   // Enable pattern follows directly from edges since release
   function automatic logic [DIGITS-1:0] expectedAn();
      int c;
      int d;
      logic [DIGITS-1:0] pat;
      c = mEdges % REFRESH_DIV;
      d = (mEdges / REFRESH_DIV) % DIGITS;
      pat = '1;
      if (c >= BLANK_CYCLES) pat[d] = 1'b0;
      return pat;
   endfunction

   // Apply one clock edge of the model with the inputs that were present at it
   function automatic void modelStep(input logic nl, input logic [5:0] lt, input logic fl);
      int prevIdx;
      prevIdx  = (mEdges / REFRESH_DIV) % DIGITS;
      mLetterQ = mSlot[prevIdx];
      if (fl) begin
         for (int i = 0; i < DIGITS; i++) mSlot[i] = NULL_CODE;
         mCount    = 0;
         mAccepted = 1'b0;
      end else if (nl && (lt < 6'd36)) begin
         for (int i = DIGITS - 1; i > 0; i--) mSlot[i] = mSlot[i-1];
         mSlot[0]  = lt;
         mCount    = (mCount < DIGITS) ? mCount + 1 : DIGITS;
         mAccepted = 1'b1;
      end else begin
         mAccepted = 1'b0;
      end
      mEdges++;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      nCompared++;
      assert (observed === expected)
      else begin
         nMismatched++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic checkAll(input string tag);
      checkOutput({tag, "_an"},       32'(an),       32'(expectedAn()));
      checkOutput({tag, "_letterQ"},  32'(letterQ),  32'(mLetterQ));
      checkOutput({tag, "_accepted"}, 32'(accepted), 32'(mAccepted));
      checkOutput({tag, "_count"},    32'(count),    32'(mCount));
   endtask

   // Drive inputs, take one edge, sample 1 unit later and compare against the model
   task automatic applyStimulus(input string tag, input logic nl, input logic [5:0] lt, input logic fl);
      newletter = nl;
      letter    = lt;
      flush     = fl;
      @(posedge clock);
      #1;
      modelStep(nl, lt, fl);
      checkAll(tag);
   endtask

   task automatic idle(input string tag, input int n);
      for (int k = 0; k < n; k++) applyStimulus(tag, 1'b0, 6'd0, 1'b0);
   endtask

   initial begin
      bit found;
      clear     = 1'b0;
      newletter = 1'b0;
      letter    = 6'd0;
      flush     = 1'b0;
      modelReset();

      // Reset values while clear is held low
      #12;
      checkAll("reset");

      // Release just after an edge; the next edge is scan cycle 1 of slot 0
      @(posedge clock);
      #1;
      clear = 1'b1;
      modelReset();
      checkAll("release");

      // Two full refresh periods of idle scanning
      idle("scan", 2 * DIGITS * REFRESH_DIV);

      // Single accept of 'A'
      applyStimulus("acceptA", 1'b1, 6'd10, 1'b0);
      idle("afterA", DIGITS * REFRESH_DIV + 2);

      // Scroll overflow: 1..5 back to back
      for (int v = 1; v <= 5; v++) applyStimulus("scroll", 1'b1, 6'(v), 1'b0);
      idle("afterScroll", DIGITS * REFRESH_DIV + 2);

      // Reject of an out-of-range code, then flush beating a strobe
      applyStimulus("reject", 1'b1, 6'b100100, 1'b0);
      idle("afterReject", 3);
      applyStimulus("flush", 1'b1, 6'b001011, 1'b1);
      idle("afterFlush", DIGITS * REFRESH_DIV + 2);

      // Randomised traffic with occasional flushes and out-of-range codes
      for (int k = 0; k < 400; k++) begin
         logic nl;
         logic fl;
         logic [5:0] lt;
         nl = ($urandom_range(0, 1) == 1);
         fl = ($urandom_range(0, 19) == 0);
         lt = 6'($urandom_range(0, 63));
         applyStimulus("random", nl, lt, fl);
      end

      // Fill some slots, then reset in the middle of a DRIVE window
      applyStimulus("preReset", 1'b1, 6'd3, 1'b0);
      applyStimulus("preReset", 1'b1, 6'd4, 1'b0);
      found = 1'b0;
      for (int k = 0; k < REFRESH_DIV + 1; k++) begin
         if (((mEdges % REFRESH_DIV) >= BLANK_CYCLES) && ((mEdges % REFRESH_DIV) < REFRESH_DIV - 1)) begin
            found = 1'b1;
            break;
         end
         applyStimulus("seekDrive", 1'b0, 6'd0, 1'b0);
      end
      nCompared++;
      if (!found) begin
         nMismatched++;
         $display("[TB] FAIL seekDrive observed=no DRIVE window expected=DRIVE window");
      end
      checkOutput("midDriveLit", 32'(&an), 32'(0));
      clear = 1'b0;
      #1;
      modelReset();
      checkAll("midReset");
      repeat (2) @(posedge clock);
      #1;
      checkAll("heldReset");
      clear = 1'b1;
      idle("restart", DIGITS * REFRESH_DIV + 3);
      applyStimulus("restartAccept", 1'b1, 6'd35, 1'b0);
      idle("restartTail", DIGITS * REFRESH_DIV);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
